// File: rtl/vram_pkg.sv
// vram_pkg: shared types, default geometry and byte-enable merge for the video RAM.
// Provides vram_state_e (IDLE/CLEAR), VRAM_* defaults and be_merge().
package vram_pkg;
  typedef enum logic {IDLE, CLEAR} vram_state_e;
  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_DEPTH = 601;
  localparam int VRAM_ADDR_W = 10;
  function automatic logic [VRAM_DATA_W-1:0] be_merge(
    input logic [VRAM_DATA_W-1:0] old_w,
    input logic [VRAM_DATA_W-1:0] new_w,
    input logic [VRAM_DATA_W/8-1:0] be
  );
    logic [VRAM_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < VRAM_DATA_W / 8; i++) r[8*i+:8] = be[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/vram_dp_if.sv
// vram_dp_if: CPU bus, video read port and clear control of the video RAM.
// master drives CS/READ/WRITE/BYTE_EN/ADDR/Data_In/CLEAR_REQ/VID_RE/VID_ADDR;
// slave returns Data_Out/READ_VALID/BUSY/VID_DATA/VID_VALID.
interface vram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic CS, READ, WRITE, CLEAR_REQ, VID_RE;
  logic [DATA_W/8-1:0] BYTE_EN;
  logic [ADDR_W-1:0] ADDR, VID_ADDR;
  logic [DATA_W-1:0] Data_In, Data_Out, VID_DATA;
  logic READ_VALID, BUSY, VID_VALID;
  modport master (
    output CS, READ, WRITE, BYTE_EN, ADDR, Data_In, CLEAR_REQ, VID_RE, VID_ADDR,
    input Data_Out, READ_VALID, BUSY, VID_DATA, VID_VALID
  );
  modport slave (
    input CS, READ, WRITE, BYTE_EN, ADDR, Data_In, CLEAR_REQ, VID_RE, VID_ADDR,
    output Data_Out, READ_VALID, BUSY, VID_DATA, VID_VALID
  );
endinterface

// File: rtl/vram_dp_mem.sv
// vram_dp_mem: dual-port array, byte-enabled write/read port A, read-only port B.
// Ports: CLK, RESET_N; a_we/a_be/a_wdata write, a_re/a_zero read -> a_rdata/a_valid;
// b_re/b_zero read -> b_rdata/b_valid. Both reads registered, read-before-write.
// *_zero forces the registered read data to 0 (out of range or blanked).
module vram_dp_mem
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH = VRAM_DEPTH,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic a_we,
  input  logic a_re,
  input  logic a_zero,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic a_valid,
  input  logic b_re,
  input  logic b_zero,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic b_valid
);
  logic [DATA_W-1:0] mem [DEPTH];
  // The array itself carries no reset so it maps onto block RAM.
  always_ff @(posedge CLK)
    if (a_we) mem[a_addr] <= be_merge(mem[a_addr], a_wdata, a_be);
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      a_rdata <= '0;
      a_valid <= 1'b0;
      b_rdata <= '0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= a_re;
      b_valid <= b_re;
      if (a_re) a_rdata <= a_zero ? '0 : mem[a_addr];
      if (b_re) b_rdata <= b_zero ? '0 : mem[b_addr];
    end
endmodule

// File: rtl/vram_dp.sv
// vram_dp: dual-port video RAM with CPU port, video read port and sequential clear engine.
// Ports: CLK, RESET_N (async, active-low), bus (vram_dp_if.slave) carrying the CPU
// bus, CLEAR_REQ/BUSY and the video read port.
module vram_dp
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH = VRAM_DEPTH,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic CLK,
  input logic RESET_N,
  vram_dp_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  vram_state_e state;
  logic [ADDR_W-1:0] cnt;
  logic busy, pend;
  logic cpu_rd, cpu_wr, a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W/8-1:0] a_be;
  logic [DATA_W-1:0] a_wdata, a_rdata, b_rdata;
  logic a_valid, b_valid;
  // pend arms the automatic clear so it fires on the first edge after reset release.
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      pend <= CLEAR_ON_RESET != 0;
    end else if (state == IDLE) begin
      pend <= 1'b0;
      if (pend || bus.CLEAR_REQ) begin
        state <= CLEAR;
        busy <= 1'b1;
      end
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (cnt == LAST) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  // READ wins over WRITE; out-of-range writes never reach the array.
  assign cpu_rd = bus.CS & bus.READ & ~busy;
  assign cpu_wr = bus.CS & bus.WRITE & ~bus.READ & ~busy & (bus.ADDR <= LAST);
  assign a_we = busy | cpu_wr;
  assign a_addr = busy ? cnt : bus.ADDR;
  assign a_be = busy ? '1 : bus.BYTE_EN;
  assign a_wdata = busy ? '0 : bus.Data_In;
  vram_dp_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .a_we(a_we),
    .a_re(cpu_rd),
    .a_zero(bus.ADDR > LAST),
    .a_addr(a_addr),
    .a_be(a_be),
    .a_wdata(a_wdata),
    .a_rdata(a_rdata),
    .a_valid(a_valid),
    .b_re(bus.VID_RE),
    .b_zero(busy | (bus.VID_ADDR > LAST)),
    .b_addr(bus.VID_ADDR),
    .b_rdata(b_rdata),
    .b_valid(b_valid)
  );
  assign bus.Data_Out = a_rdata;
  assign bus.READ_VALID = a_valid;
  assign bus.VID_DATA = b_rdata;
  assign bus.VID_VALID = b_valid;
  assign bus.BUSY = busy;
endmodule

// File: tb/tb_vram_dp.sv
// tb_vram_dp: directed self-checking bench for vram_dp.
module tb_vram_dp;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int checks = 0;
  int failures = 0;
  vram_dp_if bus ();
  vram_dp dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
  always #5 CLK = ~CLK;
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  task automatic idle_inputs();
    bus.CS = 0; bus.READ = 0; bus.WRITE = 0; bus.BYTE_EN = '0; bus.ADDR = '0;
    bus.Data_In = '0; bus.CLEAR_REQ = 0; bus.VID_RE = 0; bus.VID_ADDR = '0;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (bus.BUSY && n < 2000) begin
      n++;
      @(negedge CLK);
    end
  endtask
  task automatic cpu_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.CS = 1; bus.WRITE = 1; bus.ADDR = a; bus.Data_In = d; bus.BYTE_EN = be;
    @(negedge CLK);
    bus.CS = 0; bus.WRITE = 0;
  endtask
  task automatic cpu_read(input logic [9:0] a, output logic [31:0] d, output logic v);
    bus.CS = 1; bus.READ = 1; bus.ADDR = a;
    @(negedge CLK);
    d = bus.Data_Out; v = bus.READ_VALID;
    bus.CS = 0; bus.READ = 0;
  endtask
  task automatic vid_read(input logic [9:0] a, output logic [31:0] d, output logic v);
    bus.VID_RE = 1; bus.VID_ADDR = a;
    @(negedge CLK);
    d = bus.VID_DATA; v = bus.VID_VALID;
    bus.VID_RE = 0;
  endtask
  task automatic test_reset();
    int n;
    idle_inputs();
    RESET_N = 0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.Data_Out, bus.VID_DATA, bus.READ_VALID, bus.VID_VALID, bus.BUSY} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got do=%h vd=%h rv=%b vv=%b busy=%b exp all 0",
               bus.Data_Out, bus.VID_DATA, bus.READ_VALID, bus.VID_VALID, bus.BUSY);
    end
    RESET_N = 1;
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL reset_clear_start busy=%b exp 1", bus.BUSY); end
    count_busy(n);
    checks++;
    if (n != 601) begin failures++; $display("FAIL reset_clear_len got=%0d exp 601", n); end
  endtask
  task automatic test_cleared_reads();
    logic [31:0] d; logic v;
    logic [9:0] addrs [3];
    addrs = '{10'd0, 10'd300, 10'd600};
    foreach (addrs[i]) begin
      cpu_read(addrs[i], d, v);
      checks++;
      if (d !== 32'h0 || v !== 1'b1) begin
        failures++;
        $display("FAIL cleared_read addr=%0d got d=%h v=%b exp d=0 v=1", addrs[i], d, v);
      end
    end
  endtask
  task automatic test_byte_enable();
    logic [31:0] d; logic v;
    cpu_write(10'd5, 32'hDEADBEEF, 4'b1111);
    cpu_write(10'd5, 32'h000000AA, 4'b0001);
    cpu_read(10'd5, d, v);
    checks++;
    if (d !== 32'hDEADBEAA || v !== 1'b1) begin
      failures++; $display("FAIL be_merge got d=%h v=%b exp d=deadbeaa v=1", d, v);
    end
    @(negedge CLK);
    checks++;
    if (bus.READ_VALID !== 1'b0 || bus.Data_Out !== 32'hDEADBEAA) begin
      failures++; $display("FAIL read_pulse got v=%b d=%h exp v=0 d=deadbeaa", bus.READ_VALID, bus.Data_Out);
    end
    cpu_write(10'd5, 32'hFFFFFFFF, 4'b0000);
    cpu_read(10'd5, d, v);
    checks++;
    if (d !== 32'hDEADBEAA) begin failures++; $display("FAIL be_zero_noop got=%h exp deadbeaa", d); end
    bus.CS = 1; bus.READ = 1; bus.WRITE = 1; bus.ADDR = 10'd5; bus.Data_In = 32'h11111111; bus.BYTE_EN = 4'hF;
    @(negedge CLK);
    bus.CS = 0; bus.READ = 0; bus.WRITE = 0;
    checks++;
    if (bus.Data_Out !== 32'hDEADBEAA || bus.READ_VALID !== 1'b1) begin
      failures++; $display("FAIL rw_as_read got d=%h v=%b exp deadbeaa 1", bus.Data_Out, bus.READ_VALID);
    end
    cpu_read(10'd5, d, v);
    checks++;
    if (d !== 32'hDEADBEAA) begin failures++; $display("FAIL rw_no_write got=%h exp deadbeaa", d); end
  endtask
  task automatic test_collision();
    logic [31:0] d; logic v;
    cpu_write(10'd10, 32'hCAFEF00D, 4'hF);
    bus.CS = 1; bus.WRITE = 1; bus.ADDR = 10'd10; bus.Data_In = 32'h12345678; bus.BYTE_EN = 4'hF;
    bus.VID_RE = 1; bus.VID_ADDR = 10'd10;
    @(negedge CLK);
    bus.CS = 0; bus.WRITE = 0;
    checks++;
    if (bus.VID_DATA !== 32'hCAFEF00D || bus.VID_VALID !== 1'b1) begin
      failures++; $display("FAIL collision_old got d=%h v=%b exp cafef00d 1", bus.VID_DATA, bus.VID_VALID);
    end
    @(negedge CLK);
    bus.VID_RE = 0;
    checks++;
    if (bus.VID_DATA !== 32'h12345678) begin failures++; $display("FAIL collision_new got=%h exp 12345678", bus.VID_DATA); end
    @(negedge CLK);
    checks++;
    if (bus.VID_VALID !== 1'b0 || bus.VID_DATA !== 32'h12345678) begin
      failures++; $display("FAIL vid_hold got v=%b d=%h exp 0 12345678", bus.VID_VALID, bus.VID_DATA);
    end
    cpu_read(10'd10, d, v);
    checks++;
    if (d !== 32'h12345678) begin failures++; $display("FAIL cpu_after_write got=%h exp 12345678", d); end
  endtask
  task automatic test_out_of_range();
    logic [31:0] d; logic v;
    cpu_write(10'd700, 32'h55555555, 4'hF);
    cpu_read(10'd700, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin failures++; $display("FAIL oor_read got d=%h v=%b exp 0 1", d, v); end
    cpu_read(10'd600, d, v);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL oor_600_unchanged got=%h exp 0", d); end
    cpu_write(10'd600, 32'h60060060, 4'hF);
    vid_read(10'd700, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin failures++; $display("FAIL oor_vid got d=%h v=%b exp 0 1", d, v); end
    vid_read(10'd600, d, v);
    checks++;
    if (d !== 32'h60060060) begin failures++; $display("FAIL last_word got=%h exp 60060060", d); end
  endtask
  task automatic test_clear_req();
    logic [31:0] d; logic v;
    int n;
    cpu_write(10'd500, 32'hA5A5A5A5, 4'hF);
    bus.CLEAR_REQ = 1;
    @(negedge CLK);
    bus.CLEAR_REQ = 0;
    checks++;
    if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL clear_req_start busy=%b exp 1", bus.BUSY); end
    n = 0;
    while (bus.BUSY && n < 2000) begin
      n++;
      if (n == 50) begin
        bus.CS = 1; bus.WRITE = 1; bus.ADDR = 10'd20; bus.Data_In = 32'h77777777; bus.BYTE_EN = 4'hF;
      end
      if (n == 51) begin
        bus.WRITE = 0; bus.READ = 1; bus.ADDR = 10'd500; bus.VID_RE = 1; bus.VID_ADDR = 10'd500;
      end
      if (n == 52) begin
        checks++;
        if (bus.READ_VALID !== 1'b0) begin failures++; $display("FAIL busy_read_dropped v=%b exp 0", bus.READ_VALID); end
        checks++;
        if (bus.VID_DATA !== 32'h0 || bus.VID_VALID !== 1'b1) begin
          failures++; $display("FAIL busy_vid_blank got d=%h v=%b exp 0 1", bus.VID_DATA, bus.VID_VALID);
        end
        bus.CS = 0; bus.READ = 0; bus.VID_RE = 0;
      end
      bus.CLEAR_REQ = n == 60;
      @(negedge CLK);
    end
    bus.CLEAR_REQ = 0;
    checks++;
    if (n != 601) begin failures++; $display("FAIL clear_req_len got=%0d exp 601", n); end
    cpu_read(10'd20, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin failures++; $display("FAIL busy_write_lost got d=%h v=%b exp 0 1", d, v); end
    cpu_read(10'd500, d, v);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL clear_req_wiped got=%h exp 0", d); end
  endtask
  task automatic test_reset_mid_clear();
    logic [31:0] d; logic v;
    int n;
    cpu_write(10'd100, 32'h11112222, 4'hF);
    cpu_write(10'd400, 32'h33334444, 4'hF);
    cpu_write(10'd5, 32'h0BADF00D, 4'hF);
    cpu_read(10'd5, d, v);
    checks++;
    if (d !== 32'h0BADF00D) begin failures++; $display("FAIL pre_reset_cpu got=%h exp 0badf00d", d); end
    vid_read(10'd400, d, v);
    checks++;
    if (d !== 32'h33334444) begin failures++; $display("FAIL pre_reset_vid got=%h exp 33334444", d); end
    bus.CLEAR_REQ = 1;
    @(negedge CLK);
    bus.CLEAR_REQ = 0;
    repeat (200) @(negedge CLK);
    RESET_N = 0;
    @(negedge CLK);
    checks++;
    if ({bus.Data_Out, bus.VID_DATA, bus.READ_VALID, bus.VID_VALID, bus.BUSY} !== '0) begin
      failures++;
      $display("FAIL midclear_reset_outputs got do=%h vd=%h rv=%b vv=%b busy=%b exp all 0",
               bus.Data_Out, bus.VID_DATA, bus.READ_VALID, bus.VID_VALID, bus.BUSY);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1;
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL restart_start busy=%b exp 1", bus.BUSY); end
    count_busy(n);
    checks++;
    if (n != 601) begin failures++; $display("FAIL restart_len got=%0d exp 601", n); end
    cpu_read(10'd100, d, v);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL restart_wiped_100 got=%h exp 0", d); end
    cpu_read(10'd400, d, v);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL restart_wiped_400 got=%h exp 0", d); end
  endtask
  initial begin
    test_reset();
    test_cleared_reads();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_clear_req();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
